// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM built-in self-test engine.
// State codes double as the task_phase debug value.
package ram_bist_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_WRITE0 = 4'd1,
      ST_READ0  = 4'd2,
      ST_WRITE1 = 4'd3,
      ST_READ1  = 4'd4,
      ST_DONE   = 4'd5
   } bist_state_e;

   localparam logic [15:0] FAIL_COUNT_MAX = 16'hFFFF;

   // E(a) = seed ^ {~a, a} for an aw-bit address; callers narrow the result.
   function automatic logic [63:0] pattern_word(
      input logic [63:0] seed,
      input logic [31:0] addr,
      input int unsigned aw,
      input logic        inverted
   );
      logic [63:0] addr64;
      logic [63:0] mask;
      logic [63:0] word;
      addr64 = {32'b0, addr};
      mask   = (64'd1 << aw) - 64'd1;
      word   = seed ^ ((addr64 & mask) | ((~addr64 & mask) << aw));
      return inverted ? ~word : word;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == FAIL_COUNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ram_bist_address_walker.sv
// Walks base..base+length-1 modulo 2^ADDRESS_WIDTH, restarting at base
// after the last element so consecutive passes need no reload.
module ram_bist_address_walker #(
   parameter int ADDRESS_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     advance,
   input  logic [ADDRESS_WIDTH-1:0] base_address,
   input  logic [ADDRESS_WIDTH:0]   length,
   output logic [ADDRESS_WIDTH-1:0] address,
   output logic [ADDRESS_WIDTH-1:0] next_address,
   output logic                     last
);

   logic [ADDRESS_WIDTH-1:0] base_q, base_d;
   logic [ADDRESS_WIDTH:0]   length_q, length_d;
   logic [ADDRESS_WIDTH-1:0] address_q, address_d;
   logic [ADDRESS_WIDTH:0]   remaining_q, remaining_d;

   assign last         = (remaining_q == (ADDRESS_WIDTH+1)'(1));
   assign address      = address_q;
   assign next_address = address_d;

   always_comb begin
      base_d      = base_q;
      length_d    = length_q;
      address_d   = address_q;
      remaining_d = remaining_q;
      if (load) begin
         base_d      = base_address;
         length_d    = length;
         address_d   = base_address;
         remaining_d = length;
      end else if (advance) begin
         if (last) begin
            address_d   = base_q;
            remaining_d = length_q;
         end else begin
            address_d   = address_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         base_q      <= '0;
         length_q    <= '0;
         address_q   <= '0;
         remaining_q <= '0;
      end else begin
         base_q      <= base_d;
         length_q    <= length_d;
         address_q   <= address_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: rtl/ram_bist_engine.sv
// March-style self-test initiator for the distributed RAM port:
// write E(a), read/compare, write ~E(a), read/compare, then report.
module ram_bist_engine
   import ram_bist_pkg::*;
#(
   parameter int ADDRESS_WIDTH        = 16,
   parameter int DATA_WIDTH           = 32,
   parameter int ENABLE_INVERTED_PASS = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] base_address,
   input  logic [ADDRESS_WIDTH:0]   length,
   input  logic [DATA_WIDTH-1:0]    seed,
   output logic                     ram_write_enabled,
   output logic [ADDRESS_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0]    ram_write_data,
   input  logic [DATA_WIDTH-1:0]    ram_read_data,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [15:0]              fail_count,
   output logic [ADDRESS_WIDTH-1:0] first_fail_address,
   output logic [3:0]               task_phase
);

   bist_state_e state_q, state_d;
   logic [DATA_WIDTH-1:0]    seed_q, seed_d;
   logic [15:0]              fail_count_q, fail_count_d;
   logic [ADDRESS_WIDTH-1:0] first_fail_q, first_fail_d;
   logic                     pass_q, pass_d;
   logic                     we_q, we_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [3:0]               phase_q, phase_d;

   logic                     walk_load;
   logic                     walk_advance;
   logic [ADDRESS_WIDTH-1:0] addr_cur;
   logic [ADDRESS_WIDTH-1:0] addr_next;
   logic                     addr_last;
   logic [DATA_WIDTH-1:0]    expected;
   logic                     mismatch;

   ram_bist_address_walker #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
   ) u_walker (
      .clock       (clock),
      .reset       (reset),
      .load        (walk_load),
      .advance     (walk_advance),
      .base_address(base_address),
      .length      (length),
      .address     (addr_cur),
      .next_address(addr_next),
      .last        (addr_last)
   );

   always_comb begin
      state_d      = state_q;
      seed_d       = seed_q;
      fail_count_d = fail_count_q;
      first_fail_d = first_fail_q;
      walk_load    = 1'b0;
      walk_advance = 1'b0;
      mismatch     = 1'b0;
      expected     = DATA_WIDTH'(pattern_word(64'(seed_q), 32'(addr_cur),
                                              ADDRESS_WIDTH,
                                              state_q == ST_READ1));
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               seed_d       = seed;
               fail_count_d = '0;
               first_fail_d = '0;
               if (length == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d   = ST_WRITE0;
                  walk_load = 1'b1;
               end
            end
         end
         ST_WRITE0: begin
            walk_advance = 1'b1;
            if (addr_last) state_d = ST_READ0;
         end
         ST_READ0: begin
            walk_advance = 1'b1;
            mismatch     = (ram_read_data != expected);
            if (addr_last) begin
               state_d = (ENABLE_INVERTED_PASS != 0) ? ST_WRITE1 : ST_DONE;
            end
         end
         ST_WRITE1: begin
            walk_advance = 1'b1;
            if (addr_last) state_d = ST_READ1;
         end
         ST_READ1: begin
            walk_advance = 1'b1;
            mismatch     = (ram_read_data != expected);
            if (addr_last) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (mismatch) begin
         fail_count_d = sat_inc(fail_count_q);
         if (fail_count_q == '0) first_fail_d = addr_cur;
      end

      // Outputs are registered from the next state so they line up with it.
      pass_d  = (state_d == ST_DONE) && (fail_count_d == '0);
      we_d    = (state_d == ST_WRITE0) || (state_d == ST_WRITE1);
      busy_d  = we_d || (state_d == ST_READ0) || (state_d == ST_READ1);
      done_d  = (state_d == ST_DONE);
      phase_d = state_d;
      wdata_d = '0;
      if (we_d) begin
         wdata_d = DATA_WIDTH'(pattern_word(64'(seed_d), 32'(addr_next),
                                            ADDRESS_WIDTH,
                                            state_d == ST_WRITE1));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         seed_q       <= '0;
         fail_count_q <= '0;
         first_fail_q <= '0;
         pass_q       <= 1'b0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         phase_q      <= '0;
      end else begin
         state_q      <= state_d;
         seed_q       <= seed_d;
         fail_count_q <= fail_count_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         phase_q      <= phase_d;
      end
   end

   assign ram_write_enabled  = we_q;
   assign ram_address        = addr_cur;
   assign ram_write_data     = wdata_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign pass               = pass_q;
   assign fail_count         = fail_count_q;
   assign first_fail_address = first_fail_q;
   assign task_phase         = phase_q;

endmodule
